// File: rtl/sd_rx_pkg.sv
// Shared types and constants for the SD receive burst filler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BURST = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_EOB     = 3'b111;
    localparam logic [1:0]  BTE_LINEAR  = 2'b00;
    localparam logic [31:0] WORD_STEP   = 32'd4;

endpackage

// File: rtl/sd_sync_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest word.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: pushes while full are dropped unless a pop happens in the same cycle.
module sd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    // count never exceeds DEPTH, a power of two, so the MSB alone means full
    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // a simultaneous pop frees the slot, so a full FIFO may still accept the push
    assign push = wr && (!full || rd);
    assign pop  = rd && !empty;

    // pointer and occupancy update; flush wins over any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage array; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sd_rx_burst_filler.sv
// Buffers SD receive words and writes them to memory as Wishbone incrementing bursts.
// Latency: a burst starts two cycles after enough words for it are buffered.
// Backpressure: Wishbone ack paces pops; wr while full drops the word (full is advisory).
module sd_rx_burst_filler
    import sd_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int BURST = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      adr,
    input  logic [LEN_W-1:0] xfer_words,
    input  logic [31:0]      dat_i,
    input  logic             wr,
    output logic             full,
    output logic             done,
    output logic             err,
    output logic [31:0]      m_wb_adr_o,
    output logic [31:0]      m_wb_dat_o,
    output logic             m_wb_we_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    output logic [2:0]       m_wb_cti_o,
    output logic [1:0]       m_wb_bte_o,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic             en_q;
    logic [31:0]      adr_cnt_q, adr_cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CW-1:0]    beat_left_q, beat_left_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             in_burst;
    logic             en_rise;
    logic [CW-1:0]    beats;
    logic             fifo_rd, fifo_flush, fifo_full, fifo_empty;
    logic [31:0]      fifo_dout;
    logic [CW-1:0]    fifo_count;

    assign in_burst   = (state_q == ST_BURST);
    assign en_rise    = en && !en_q;
    // only a clean ack (no err) in an enabled burst consumes a word
    assign fifo_rd    = in_burst && en && m_wb_ack_i && !m_wb_err_i && !fifo_empty;
    // dropping en discards any buffered words so a new transfer starts clean
    assign fifo_flush = !en;

    sd_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .wr    (wr),
        .din   (dat_i),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // size of the next burst: a full BURST, or whatever is left of the transfer
    always_comb begin
        beats = CW'(BURST);
        if (rem_q < LEN_W'(BURST)) beats = CW'(rem_q);
    end

    // next-state and datapath update; en low aborts from any state
    always_comb begin
        state_d     = state_q;
        adr_cnt_d   = adr_cnt_q;
        rem_d       = rem_q;
        beat_left_d = beat_left_q;
        done_d      = done_q;
        err_d       = err_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_rise) begin
                        state_d   = ST_WAIT;
                        adr_cnt_d = adr;
                        rem_d     = xfer_words;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (fifo_count >= beats) begin
                        state_d     = ST_BURST;
                        beat_left_d = beats;
                    end
                end
                ST_BURST: begin
                    // err takes precedence over a simultaneous ack; nothing advances
                    if (m_wb_err_i) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (m_wb_ack_i) begin
                        adr_cnt_d   = adr_cnt_q + WORD_STEP;
                        rem_d       = rem_q - 1'b1;
                        beat_left_d = beat_left_q - 1'b1;
                        // leaving BURST drops cyc for at least one cycle
                        if (beat_left_q == CW'(1)) begin
                            if (rem_q == LEN_W'(1)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_DONE, ST_ERROR: state_d = state_q;
                default:           state_d = ST_IDLE;
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            adr_cnt_q   <= '0;
            rem_q       <= '0;
            beat_left_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en;
            adr_cnt_q   <= adr_cnt_d;
            rem_q       <= rem_d;
            beat_left_q <= beat_left_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // bus outputs are decoded straight from registered state, so rst clears them at once
    assign m_wb_cyc_o = in_burst;
    assign m_wb_stb_o = in_burst;
    assign m_wb_we_o  = in_burst;
    assign m_wb_adr_o = rst ? 32'd0 : ((state_q == ST_IDLE) ? adr : adr_cnt_q);
    assign m_wb_dat_o = in_burst ? fifo_dout : 32'd0;
    assign m_wb_cti_o = in_burst ? ((beat_left_q == CW'(1)) ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign m_wb_bte_o = BTE_LINEAR;
    assign full       = fifo_full;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/sd_rx_burst_filler.md
SD_RX_BURST_FILLER -- requirements
Module: sd_rx_burst_filler

Interface
REQ-001 Parameter DEPTH, default 16: receive FIFO depth in 32-bit words, power of two, at least 2.
REQ-002 Parameter BURST, default 4: maximum Wishbone beats per cycle, power of two, at most DEPTH.
REQ-003 Parameter LEN_W, default 16: width of the transfer-length field.
REQ-004 Port clk, input, 1: the only clock; all logic is rising-edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port en, input, 1: transfer enable; its rising edge starts a transfer and its deassertion aborts one.
REQ-007 Port adr, input, 32: destination base byte address, sampled on en rise.
REQ-008 Port xfer_words, input, LEN_W: transfer length in words, sampled on en rise.
REQ-009 Port dat_i, input, 32: data word from the SD data path.
REQ-010 Port wr, input, 1: write strobe for dat_i.
REQ-011 Port full, output, 1: FIFO full.
REQ-012 Port done, output, 1: transfer complete, sticky.
REQ-013 Port err, output, 1: bus error, sticky.
REQ-014 Ports m_wb_adr_o (32), m_wb_dat_o (32), m_wb_we_o (1), m_wb_cyc_o (1), m_wb_stb_o (1), m_wb_cti_o (3) and m_wb_bte_o (2) are outputs; m_wb_ack_i (1) and m_wb_err_i (1) are inputs.

Function
REQ-015 The FIFO SHALL be synchronous, show-ahead, with a count of clog2(DEPTH)+1 bits; full is asserted when count equals DEPTH.
REQ-016 A wr pulse while full is deasserted SHALL push dat_i; a wr pulse while full is asserted SHALL drop the word and leave the FIFO unchanged.
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged; this SHALL also hold when the FIFO is full.
REQ-018 FSM states: IDLE, WAIT, BURST, DONE, ERROR.
REQ-019 IDLE -> WAIT on en rise: load address counter := adr, remaining := xfer_words; done and err are cleared.
REQ-020 WAIT -> DONE in the next cycle when remaining = 0.
REQ-021 WAIT -> BURST when count >= beats, where beats = min(BURST, remaining); cyc, stb and we assert in the next cycle.
REQ-022 In BURST, m_wb_dat_o SHALL equal the FIFO head and m_wb_adr_o SHALL equal the address counter.
REQ-023 m_wb_cti_o SHALL be 3'b010 on every beat except the last, 3'b111 on the last beat, and 3'b111 when beats = 1.
REQ-024 m_wb_bte_o SHALL be 2'b00 (linear) at all times.
REQ-025 Each ack in BURST SHALL pop one word, add 4 to the address counter (32-bit wrap at 2^32) and decrement remaining.
REQ-026 stb SHALL stay asserted with no idle beats inside a burst, giving a throughput of one word per ack.
REQ-027 After the last ack of a burst, cyc and stb SHALL deassert for at least one cycle; then next state = DONE if remaining = 0, else WAIT.
REQ-028 m_wb_err_i while cyc is asserted SHALL deassert cyc and stb in the next cycle, set err and enter ERROR; no pop occurs on that beat.
REQ-029 ack and err asserted together SHALL be treated as err.
REQ-030 DONE and ERROR SHALL hold until en deasserts, then return to IDLE; done and err stay set until the next en rise.
REQ-031 en deassert in any state SHALL, in the next cycle, drop cyc and stb, flush the FIFO, and enter IDLE without setting done.
REQ-032 ack outside BURST SHALL be ignored.
REQ-033 While IDLE, m_wb_adr_o SHALL equal adr.

Reset
REQ-034 rst SHALL force state IDLE, an empty FIFO, address counter 0 and remaining 0.
REQ-035 rst SHALL force all outputs to 0 (m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o, full, done, err).
REQ-036 rst asserted mid-burst SHALL drop cyc immediately (asynchronously), with no partial state retained.

Structure
REQ-037 Package sd_rx_pkg SHALL hold the FSM state enum, the CTI constants (CTI_CLASSIC 000, CTI_INCR 010, CTI_EOB 111), the BTE_LINEAR constant and the word byte step of 4.
REQ-038 Sub-module sd_sync_fifo SHALL be parametrised by width and depth, with ports clk, rst, flush, wr, din, rd, dout, count, full and empty.

Verification
REQ-039 xfer_words=8, adr=0x1000, BURST=4, 8 words written, zero-wait ack -> two bursts at 0x1000-0x100C and 0x1010-0x101C, cti 010,010,010,111 in each, done=1.
REQ-040 xfer_words=6, BURST=4 -> bursts of 4 and 2 beats, the second with cti 010,111; done after the 6th ack.
REQ-041 DEPTH=16, 20 wr pulses with ack withheld -> full=1 after 16 words, last 4 words dropped, count=16.
REQ-042 m_wb_err_i on beat 2 of a burst -> cyc=0 in the next cycle, err=1, done=0, address not advanced past the beat-2 address.
REQ-043 en deasserted mid-burst, then a new transfer with adr=0x2000 -> FIFO empty, first beat at 0x2000 with the new data only.
REQ-044 xfer_words=0 -> done=1 two cycles after en rise, cyc never asserted.
